// File: rtl/state_dump_unit.sv
// Streams the register file followed by data memory over a valid/ready channel,
// reading each word through the dedicated combinational read ports.
module state_dump_unit #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NUM_REGS      = 32,
  parameter int unsigned NUM_MEM_WORDS = 10,
  parameter int unsigned IDX_WIDTH     = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [4:0]            rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic [31:0]           dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_is_mem,
  output logic [IDX_WIDTH-1:0]  out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StDone} state_e;

  localparam logic [IDX_WIDTH-1:0] LastReg = IDX_WIDTH'(NUM_REGS - 1);
  localparam logic [IDX_WIDTH-1:0] LastMem = IDX_WIDTH'(NUM_MEM_WORDS - 1);

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  phase_q, phase_d;   // 0 = registers, 1 = data memory
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  is_mem_q, is_mem_d;
  logic [IDX_WIDTH-1:0]  index_q, index_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    data_d   = data_q;
    is_mem_d = is_mem_q;
    index_d  = index_q;
    valid_d  = valid_q;
    rf_addr  = '0;
    dm_addr  = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      StFetch: begin
        if (phase_q) begin
          dm_addr = 32'(cnt_q) << 2;
          data_d  = dm_data;
        end else begin
          rf_addr = 5'(cnt_q);
          data_d  = rf_data;
        end
        is_mem_d = phase_q;
        index_d  = cnt_q;
        valid_d  = 1'b1;
        state_d  = StSend;
      end
      StSend: begin
        // Output registers hold untouched until the consumer takes the word.
        if (out_ready) begin
          valid_d = 1'b0;
          if (!phase_q && (cnt_q == LastReg)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
            state_d = StFetch;
          end else if (phase_q && (cnt_q == LastMem)) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      data_q   <= '0;
      is_mem_q <= 1'b0;
      index_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      data_q   <= data_d;
      is_mem_q <= is_mem_d;
      index_q  <= index_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_is_mem = is_mem_q;
  assign out_index  = index_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

endmodule
